// File: rtl/key_filter_if.sv
// key_filter_if -- key pins and key events between the board push-buttons
// and key_filter.
//
// Signals (all KEY_W bits wide, one bit per key channel):
//   key_n       raw key pins, active-low (0 = pressed), asynchronous
//   key_press   one-cycle pulse per accepted press (and per auto-repeat)
//   key_release one-cycle pulse per accepted release
//   key_long    one-cycle pulse when a hold reaches the long-press time
//   key_level   debounced level, 1 = pressed
//
// Modports:
//   master  drives the key pins and consumes the events (board / bench side)
//   slave   the filter itself
interface key_filter_if #(
    parameter int KEY_W = 4
);
    logic [KEY_W-1:0] key_n;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_release;
    logic [KEY_W-1:0] key_long;
    logic [KEY_W-1:0] key_level;

    modport master (
        output key_n,
        input  key_press,
        input  key_release,
        input  key_long,
        input  key_level
    );

    modport slave (
        input  key_n,
        output key_press,
        output key_release,
        output key_long,
        output key_level
    );
endinterface

// File: rtl/key_filter.sv
// key_filter -- multi-key debounce and event detector.
//
// Turns raw, bouncing, active-low key pins into clean single-cycle press,
// release and long-press events plus a debounced pressed level. Each key
// channel is independent: a two-flop synchroniser followed by a five-state
// FSM (IDLE, PRESS_FILT, DOWN, HOLD, REL_FILT) with one counter and a
// long-press flag. All outputs are registered.
//
// Ports:
//   clk   system clock (50 MHz nominal)
//   rst   synchronous, active-high reset
//   kif   key_filter_if.slave: key_n in; key_press, key_release, key_long,
//         key_level out
//
// Parameters:
//   KEY_W     number of key channels
//   CNT_W     width of each per-channel counter
//   DEB_MAX   debounce terminal count (filter window is DEB_MAX+1 cycles)
//   LONG_MAX  terminal count in DOWN before the long-press event
//   REP_MAX   auto-repeat terminal count in HOLD
//
// Build option:
//   KEY_REPEAT_EN  when defined, HOLD emits a key_press every REP_MAX+1
//                  cycles; when undefined, HOLD is quiescent until release.
module key_filter #(
    parameter int               KEY_W    = 4,
    parameter int               CNT_W    = 26,
    parameter logic [CNT_W-1:0] DEB_MAX  = CNT_W'(999_999),
    parameter logic [CNT_W-1:0] LONG_MAX = CNT_W'(49_999_999),
    parameter logic [CNT_W-1:0] REP_MAX  = CNT_W'(9_999_999)
) (
    input  logic        clk,
    input  logic        rst,
    key_filter_if.slave kif
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRESS = 3'd1;
    localparam logic [2:0] ST_DOWN  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_REL   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [KEY_W-1:0] sync1_q;
    logic [KEY_W-1:0] sync2_q;

    logic [2:0]       state_q [KEY_W];
    logic [2:0]       state_d [KEY_W];
    logic [CNT_W-1:0] cnt_q   [KEY_W];
    logic [CNT_W-1:0] cnt_d   [KEY_W];
    logic [KEY_W-1:0] long_flag_q, long_flag_d;

    logic [KEY_W-1:0] press_q,   press_d;
    logic [KEY_W-1:0] release_q, release_d;
    logic [KEY_W-1:0] long_q,    long_d;
    logic [KEY_W-1:0] level_q,   level_d;

`ifndef KEY_REPEAT_EN
    // Repeat period has no meaning when auto-repeat is compiled out.
    logic unused_rep_max;
    assign unused_rep_max = ^REP_MAX;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        long_flag_d = long_flag_q;
        level_d     = level_q;
        press_d     = '0;
        release_d   = '0;
        long_d      = '0;

        for (int i = 0; i < KEY_W; i++) begin
            // sync2_q[i] == 1 means released; the release check always takes
            // priority over any terminal count in the same cycle.
            case (state_q[i])
                ST_IDLE: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_PRESS;
                        cnt_d[i]   = '0;
                    end
                end
                ST_PRESS: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_MAX) begin
                        state_d[i] = ST_DOWN;
                        cnt_d[i]   = '0;
                        press_d[i] = 1'b1;
                        level_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_DOWN: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_REL;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == LONG_MAX) begin
                        state_d[i]     = ST_HOLD;
                        cnt_d[i]       = '0;
                        long_d[i]      = 1'b1;
                        long_flag_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_REL;
                        cnt_d[i]   = '0;
                    end else begin
`ifdef KEY_REPEAT_EN
                        if (cnt_q[i] == REP_MAX) begin
                            cnt_d[i]   = '0;
                            press_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
`else
                        cnt_d[i] = '0;
`endif
                    end
                end
                ST_REL: begin
                    if (!sync2_q[i]) begin
                        // Bounce during release: go back to where we were and
                        // restart the hold timer from zero.
                        state_d[i] = long_flag_q[i] ? ST_HOLD : ST_DOWN;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_MAX) begin
                        state_d[i]     = ST_IDLE;
                        cnt_d[i]       = '0;
                        release_d[i]   = 1'b1;
                        level_d[i]     = 1'b0;
                        long_flag_d[i] = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchroniser resets to "released" so a held key is re-filtered.
            sync1_q     <= '1;
            sync2_q     <= '1;
            long_flag_q <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            level_q     <= '0;
            for (int i = 0; i < KEY_W; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q     <= kif.key_n;
            sync2_q     <= sync1_q;
            long_flag_q <= long_flag_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            level_q     <= level_d;
            for (int i = 0; i < KEY_W; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_long    = long_q;
    assign kif.key_level   = level_q;

endmodule

// File: tb/tb_key_filter.sv
// tb_key_filter -- scoreboard bench for key_filter.
//
// A driver process applies key/reset stimulus on the falling edge and, for
// every rising edge, asks a reference model for the outputs that edge must
// produce and queues them. A monitor process pops one entry after each
// rising edge and compares it against the DUT. The model works from the
// behavioural rules: a 2-cycle delayed view of the pins, a level that flips
// after DEB_MAX+2 consecutive opposite samples, and hold/repeat timers kept
// as timestamps of the last restart.
module tb_key_filter;

    localparam int KEY_W = 4;
    localparam int CNT_W = 26;
    localparam int DEB   = 9;
    localparam int LONG  = 49;
    localparam int REP   = 19;

    typedef struct packed {
        logic [KEY_W-1:0] press;
        logic [KEY_W-1:0] rel;
        logic [KEY_W-1:0] lng;
        logic [KEY_W-1:0] lvl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    key_filter_if #(.KEY_W(KEY_W)) kif ();

    key_filter #(
        .KEY_W   (KEY_W),
        .CNT_W   (CNT_W),
        .DEB_MAX (CNT_W'(DEB)),
        .LONG_MAX(CNT_W'(LONG)),
        .REP_MAX (CNT_W'(REP))
    ) dut (
        .clk(clk),
        .rst(rst),
        .kif(kif)
    );

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model state
    bit m_sy1   [KEY_W];
    bit m_sy2   [KEY_W];
    bit m_lvl   [KEY_W];
    bit m_lflag [KEY_W];
    bit m_prev  [KEY_W];
    int m_run   [KEY_W];
    int m_t0    [KEY_W];
    int m_now = 0;

    task automatic model_edge(input logic [KEY_W-1:0] kn, input logic r, output exp_t e);
        bit s;
        bit opp;
        e = '0;
        m_now++;
        for (int k = 0; k < KEY_W; k++) begin
            if (r) begin
                m_sy1[k] = 1'b1; m_sy2[k] = 1'b1; m_lvl[k] = 1'b0;
                m_lflag[k] = 1'b0; m_prev[k] = 1'b1; m_run[k] = 0; m_t0[k] = 0;
            end else begin
                s = m_sy2[k];
                m_sy2[k] = m_sy1[k];
                m_sy1[k] = kn[k];
                opp = m_lvl[k] ? s : !s;
                m_run[k] = opp ? m_run[k] + 1 : 0;
                if (m_run[k] == DEB + 2) begin
                    m_run[k]   = 0;
                    m_lflag[k] = 1'b0;
                    if (!m_lvl[k]) begin
                        m_lvl[k]   = 1'b1;
                        e.press[k] = 1'b1;
                        m_t0[k]    = m_now;
                    end else begin
                        m_lvl[k] = 1'b0;
                        e.rel[k] = 1'b1;
                    end
                end else if (m_lvl[k] && !s) begin
                    if (m_prev[k]) begin
                        m_t0[k] = m_now;
                    end else if (!m_lflag[k] && (m_now - m_t0[k]) == LONG + 1) begin
                        e.lng[k]   = 1'b1;
                        m_lflag[k] = 1'b1;
                        m_t0[k]    = m_now;
                    end
`ifdef KEY_REPEAT_EN
                    else if (m_lflag[k] && (m_now - m_t0[k]) == REP + 1) begin
                        e.press[k] = 1'b1;
                        m_t0[k]    = m_now;
                    end
`endif
                end
                m_prev[k] = s;
            end
            e.lvl[k] = m_lvl[k];
        end
    endtask

    task automatic step(input logic [KEY_W-1:0] kn, input logic r);
        exp_t e;
        @(negedge clk);
        kif.key_n = kn;
        rst       = r;
        model_edge(kn, r, e);
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [KEY_W-1:0] kn, input int n);
        for (int i = 0; i < n; i++) step(kn, 1'b0);
    endtask

    // Monitor: one expected record per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp += 4;
                if (kif.key_press !== e.press) begin
                    n_bad++;
                    $display("FAIL press cyc=%0d got=%b want=%b", cyc, kif.key_press, e.press);
                end
                if (kif.key_release !== e.rel) begin
                    n_bad++;
                    $display("FAIL release cyc=%0d got=%b want=%b", cyc, kif.key_release, e.rel);
                end
                if (kif.key_long !== e.lng) begin
                    n_bad++;
                    $display("FAIL long cyc=%0d got=%b want=%b", cyc, kif.key_long, e.lng);
                end
                if (kif.key_level !== e.lvl) begin
                    n_bad++;
                    $display("FAIL level cyc=%0d got=%b want=%b", cyc, kif.key_level, e.lvl);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rem [KEY_W];
        logic [KEY_W-1:0] kn;
        kif.key_n = '1;

        for (int i = 0; i < 3; i++) step(4'hF, 1'b1);
        hold(4'hF, 7);

        // Clean press/release on key 0
        hold(4'hE, 30);
        hold(4'hF, 20);

        // Bounce on key 1: 4 low / 4 high, never long enough
        for (int i = 0; i < 5; i++) begin
            hold(4'hD, 4);
            hold(4'hF, 4);
        end
        hold(4'hF, 20);

        // Long press on key 2
        hold(4'hB, 120);
        hold(4'hF, 20);

        // Short release glitch while in HOLD
        hold(4'hB, 70);
        hold(4'hF, 5);
        hold(4'hB, 60);
        hold(4'hF, 20);

        // Keys 0 and 3 together
        hold(4'h6, 20);
        hold(4'hF, 20);

        // Reset while key 0 is in DOWN, key kept held
        hold(4'hE, 20);
        step(4'hE, 1'b1);
        hold(4'hE, 30);
        hold(4'hF, 20);

        // Randomised runs per key, mixing glitches and long holds
        kn = '1;
        for (int k = 0; k < KEY_W; k++) rem[k] = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < KEY_W; k++) begin
                rem[k]--;
                if (rem[k] <= 0) begin
                    kn[k] = ~kn[k];
                    case ($urandom_range(0, 2))
                        0:       rem[k] = int'($urandom_range(1, DEB + 3));
                        1:       rem[k] = int'($urandom_range(DEB + 1, 40));
                        default: rem[k] = int'($urandom_range(40, 140));
                    endcase
                end
            end
            step(kn, ($urandom_range(0, 799) == 0));
        end
        hold(4'hF, 30);

        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_filter.md
# key_filter

Multi-key debounce and event detector for the board's push-buttons. It sits directly upstream of the running-light LED driver and turns raw, bouncing, active-low key pins into clean single-cycle press, release and long-press events plus a stable pressed level. The LED driver and other user-control logic consume these events as pause, speed and direction commands. One independent channel per key; all channels share one clock and reset.

## Interface
- `KEY_W`, 4: number of key channels.
- `CNT_W`, 26: width of each per-channel counter.
- `DEB_MAX`, 26'd999_999: debounce count, 20 ms at 50 MHz. Filter window is DEB_MAX+1 cycles.
- `LONG_MAX`, 26'd49_999_999: held cycles in DOWN before a long-press event (1 s).
- `REP_MAX`, 26'd9_999_999: auto-repeat period in HOLD (200 ms). Used only with `KEY_REPEAT_EN`.
- `clk` input 1: system clock, 50 MHz.
- `rst` input 1: synchronous, active-high reset.
- `key_n` input KEY_W: raw key pins, active-low (0 = pressed), asynchronous to `clk`.
- `key_press` output KEY_W: one-cycle pulse per accepted press (and per repeat).
- `key_release` output KEY_W: one-cycle pulse per accepted release.
- `key_long` output KEY_W: one-cycle pulse when hold reaches LONG_MAX.
- `key_level` output KEY_W: debounced level, 1 = pressed.

## Operation
- Synchroniser: two flops per channel on `key_n`, giving `key_sync`. Both flops reset to 1 (released). The FSM uses only `key_sync`.
- Per-channel FSM has states IDLE, PRESS_FILT, DOWN, HOLD and REL_FILT. It has one counter `cnt` (CNT_W bits) and a `long_flag`.
  - IDLE: if `key_sync`=0, go to PRESS_FILT with `cnt`=0.
  - PRESS_FILT:
    - If `key_sync`=1, go to IDLE with `cnt`=0 (bounce rejected, no event).
    - Else if `cnt`=DEB_MAX, go to DOWN with `cnt`=0, pulse `key_press` and set `key_level`=1.
    - Else increment `cnt`.
  - DOWN:
    - If `key_sync`=1, go to REL_FILT with `cnt`=0.
    - Else if `cnt`=LONG_MAX, go to HOLD with `cnt`=0, pulse `key_long` and set `long_flag`=1.
    - Else increment `cnt`.
  - HOLD: if `key_sync`=1, go to REL_FILT with `cnt`=0. Otherwise behaviour per Configuration.
  - REL_FILT:
    - If `key_sync`=0, return to HOLD if `long_flag`=1, else to DOWN. `cnt`=0 in both cases (the long timer restarts).
    - Else if `cnt`=DEB_MAX, go to IDLE, pulse `key_release`, set `key_level`=0 and clear `long_flag`.
    - Else increment `cnt`.
- Release-check priority: the release check (`key_sync`=1) wins over the terminal-count check in DOWN and HOLD in the same cycle.
- Counter range: counters never exceed their MAX and never wrap.
- Output registers: all outputs are registered. Pulses are high for exactly one cycle.
- Channel independence: channels are fully independent. Simultaneous events on different keys are all reported in the same cycle.

## Timing
- Reset values: on `rst`=1 at a clock edge, all outputs are 0, all FSMs are IDLE, all `cnt` and `long_flag` are 0, and the synchroniser flops are 1. Reset mid-press discards the press and emits no release. After reset deasserts with the key still held, a fresh press is detected through normal filtering.
- Press latency: `key_n` sampled low at edge k and held → `key_press` high for the cycle after edge k+DEB_MAX+3.
- Release latency: release is symmetric, with `key_release` high after edge k+DEB_MAX+3 from the first high sample.
- Long-press timing: `key_long` fires LONG_MAX+1 cycles after the `key_press` cycle.
- Minimum accepted pulse: any low (or high) glitch shorter than DEB_MAX+1 synchronised cycles produces no event.

## Configuration
- `KEY_REPEAT_EN` defined:
  - In HOLD, `cnt` counts to REP_MAX, then pulses `key_press` and reloads to 0.
  - The first repeat occurs REP_MAX+1 cycles after `key_long`.
  - `key_long` still pulses once.
- `KEY_REPEAT_EN` undefined:
  - HOLD is quiescent: `cnt` is held at 0 and no further pulses occur until release.
  - REP_MAX is unused.

## Test plan
Bench overrides for all scenarios: DEB_MAX=9, LONG_MAX=49, REP_MAX=19, KEY_W=4.
- Clean press: key_n[0]=0 from edge 10, held 30 cycles → `key_press[0]` single pulse after edge 22, `key_level[0]`=1; release at edge 40 → `key_release[0]` after edge 52; no `key_long`.
- Bounce rejection: key_n[1] toggles low/high every 4 cycles for 40 cycles, then stays high → no pulses, `key_level[1]`=0 throughout.
- Long press: key_n[2]=0 held 120 cycles → `key_press` then `key_long` exactly 50 cycles later. With `KEY_REPEAT_EN`, extra `key_press` pulses every 20 cycles after `key_long`. Without it, none.
- Release bounce in HOLD: one 5-cycle high glitch during HOLD → no `key_release`, state returns to HOLD, no second `key_long`.
- Simultaneous keys: key_n[0] and key_n[3] fall on the same edge → both `key_press` bits pulse in the same cycle.
- Reset mid-hold: assert `rst` for 1 cycle while key_n[0] is held in DOWN → outputs 0 next cycle, no `key_release`; with the key still held, `key_press` recurs DEB_MAX+3 cycles after the first post-reset edge.
